// File: rtl/vx_rop_dcr_bank.sv
// vx_rop_dcr_bank: double-buffered ROP DCR state with drain-gated commit and registered per-RT lookup.
module vx_rop_dcr_bank #(
  parameter int NUM_RT       = 4,
  parameter int NUM_GLOBAL   = 16,
  parameter int PITCH_BITS   = 16,
  parameter int MAX_INFLIGHT = 64,
  parameter int ADDR_BITS    = 8,
  localparam int RT_BITS     = (NUM_RT > 1) ? $clog2(NUM_RT) : 1,
  localparam int CNT_BITS    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dcr_wr_valid,
  input  logic [ADDR_BITS-1:0]     dcr_wr_addr,
  input  logic [31:0]              dcr_wr_data,
  output logic                     dcr_wr_err,
  input  logic                     commit_valid,
  output logic                     commit_ready,
  output logic                     req_block,
  input  logic                     req_fire,
  input  logic                     rsp_fire,
  output logic                     inflight_full,
  input  logic                     rd_valid,
  input  logic [RT_BITS-1:0]       rd_rt_idx,
  output logic                     rd_valid_o,
  output logic [31:0]              cbuf_addr,
  output logic [PITCH_BITS-1:0]    cbuf_pitch,
  output logic [3:0]               cbuf_writemask,
  output logic [NUM_GLOBAL*32-1:0] global_state
);
  localparam int GBASE = 3 * NUM_RT;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_n;
  logic [CNT_BITS-1:0] cnt;
  logic [RT_BITS-1:0] rd_idx;
  logic wr_ok, rd_hit;
  logic [31:0] sh_addr [NUM_RT];
  logic [31:0] ac_addr [NUM_RT];
  logic [PITCH_BITS-1:0] sh_pitch [NUM_RT];
  logic [PITCH_BITS-1:0] ac_pitch [NUM_RT];
  logic [3:0] sh_mask [NUM_RT];
  logic [3:0] ac_mask [NUM_RT];
  logic [31:0] sh_glob [NUM_GLOBAL];
  logic [31:0] ac_glob [NUM_GLOBAL];
  always_comb begin
    req_block = commit_valid | (state == DRAIN);
    commit_ready = req_block & (cnt == '0) & ~req_fire;
    inflight_full = cnt == CNT_BITS'(MAX_INFLIGHT);
    state_n = commit_ready ? IDLE : (req_block ? DRAIN : IDLE);
    wr_ok = int'(dcr_wr_addr) < GBASE + NUM_GLOBAL;
    rd_hit = rd_valid_o & (int'(rd_idx) < NUM_RT);
    cbuf_addr = rd_hit ? ac_addr[rd_idx] : '0;
    cbuf_pitch = rd_hit ? ac_pitch[rd_idx] : '0;
    cbuf_writemask = rd_hit ? ac_mask[rd_idx] : '0;
    global_state = '0;
    for (int g = 0; g < NUM_GLOBAL; g++) global_state[g*32 +: 32] = ac_glob[g];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_valid_o <= 1'b0;
      rd_idx <= '0;
      dcr_wr_err <= 1'b0;
      for (int r = 0; r < NUM_RT; r++) begin
        sh_addr[r] <= '0;
        ac_addr[r] <= '0;
        sh_pitch[r] <= '0;
        ac_pitch[r] <= '0;
        sh_mask[r] <= 4'hF;
        ac_mask[r] <= 4'hF;
      end
      for (int g = 0; g < NUM_GLOBAL; g++) begin
        sh_glob[g] <= '0;
        ac_glob[g] <= '0;
      end
    end else begin
      state <= state_n;
      if (req_fire & ~rsp_fire & ~inflight_full) cnt <= cnt + CNT_BITS'(1);
      else if (rsp_fire & ~req_fire & (cnt != '0)) cnt <= cnt - CNT_BITS'(1);
      rd_valid_o <= rd_valid;
      if (rd_valid) rd_idx <= rd_rt_idx;
      dcr_wr_err <= dcr_wr_valid & ~wr_ok;
      // the copy reads pre-write shadow, so a same-cycle write waits for the next commit
      if (commit_ready) begin
        ac_addr <= sh_addr;
        ac_pitch <= sh_pitch;
        ac_mask <= sh_mask;
        ac_glob <= sh_glob;
      end
      if (dcr_wr_valid) begin
        for (int r = 0; r < NUM_RT; r++) begin
          if (int'(dcr_wr_addr) == 3 * r) sh_addr[r] <= dcr_wr_data;
          if (int'(dcr_wr_addr) == 3 * r + 1) sh_pitch[r] <= dcr_wr_data[PITCH_BITS-1:0];
          if (int'(dcr_wr_addr) == 3 * r + 2) sh_mask[r] <= dcr_wr_data[3:0];
        end
        for (int g = 0; g < NUM_GLOBAL; g++)
          if (int'(dcr_wr_addr) == GBASE + g) sh_glob[g] <= dcr_wr_data;
      end
    end
  end
endmodule

// File: tb/tb_vx_rop_dcr_bank.sv
// tb_vx_rop_dcr_bank: directed vector table, counter/reset sequences and random traffic against an array-based model.
module tb_vx_rop_dcr_bank;
  localparam int NRT = 4, NG = 16, PB = 16, MAXI = 64, AB = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic wv = 0, cv = 0, rf = 0, sf = 0, rv = 0;
  logic [AB-1:0] wa = '0;
  logic [31:0] wd = '0;
  logic [1:0] ri = '0;
  logic dcr_wr_err, commit_ready, req_block, inflight_full, rd_valid_o;
  logic [31:0] cbuf_addr;
  logic [PB-1:0] cbuf_pitch;
  logic [3:0] cbuf_writemask;
  logic [NG*32-1:0] global_state;
  always #5 clk = ~clk;
  vx_rop_dcr_bank dut (
    .clk(clk), .reset(reset), .dcr_wr_valid(wv), .dcr_wr_addr(wa), .dcr_wr_data(wd),
    .dcr_wr_err(dcr_wr_err), .commit_valid(cv), .commit_ready(commit_ready),
    .req_block(req_block), .req_fire(rf), .rsp_fire(sf), .inflight_full(inflight_full),
    .rd_valid(rv), .rd_rt_idx(ri), .rd_valid_o(rd_valid_o), .cbuf_addr(cbuf_addr),
    .cbuf_pitch(cbuf_pitch), .cbuf_writemask(cbuf_writemask), .global_state(global_state)
  );
  int total = 0, bad = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_w(string nm, logic [NG*32-1:0] act, logic [NG*32-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  logic [31:0] m_sa [NRT], m_aa [NRT], m_sg [NG], m_ag [NG];
  logic [PB-1:0] m_sp [NRT], m_ap [NRT];
  logic [3:0] m_sm [NRT], m_am [NRT];
  int m_cnt, m_idx;
  bit m_pend, m_rv, m_err;
  task automatic model_reset();
    for (int i = 0; i < NRT; i++) begin
      m_sa[i] = 0; m_aa[i] = 0; m_sp[i] = 0; m_ap[i] = 0; m_sm[i] = 4'hF; m_am[i] = 4'hF;
    end
    for (int i = 0; i < NG; i++) begin
      m_sg[i] = 0; m_ag[i] = 0;
    end
    m_cnt = 0; m_idx = 0; m_pend = 0; m_rv = 0; m_err = 0;
  endtask
  function automatic bit m_block();
    return cv || m_pend;
  endfunction
  function automatic bit m_ready();
    return m_block() && m_cnt == 0 && !rf;
  endfunction
  task automatic model_check();
    logic [NG*32-1:0] g;
    bit hit;
    for (int i = 0; i < NG; i++) g[i*32 +: 32] = m_ag[i];
    hit = m_rv && m_idx < NRT;
    chk("commit_ready", commit_ready, m_ready());
    chk("req_block", req_block, m_block());
    chk("inflight_full", inflight_full, m_cnt == MAXI);
    chk("rd_valid_o", rd_valid_o, m_rv);
    chk("dcr_wr_err", dcr_wr_err, m_err);
    chk("cbuf_addr", cbuf_addr, hit ? m_aa[m_idx] : 0);
    chk("cbuf_pitch", cbuf_pitch, hit ? m_ap[m_idx] : 0);
    chk("cbuf_writemask", cbuf_writemask, hit ? m_am[m_idx] : 0);
    chk_w("global_state", global_state, g);
  endtask
  task automatic model_step();
    bit rdy;
    int a;
    if (reset) begin
      model_reset();
      return;
    end
    rdy = m_ready();
    if (rdy) begin
      m_aa = m_sa; m_ap = m_sp; m_am = m_sm; m_ag = m_sg;
    end
    m_pend = m_block() && !rdy;
    a = int'(wa);
    m_err = wv && a >= 3 * NRT + NG;
    if (wv && a < 3 * NRT) begin
      if (a % 3 == 0) m_sa[a / 3] = wd;
      else if (a % 3 == 1) m_sp[a / 3] = wd[PB-1:0];
      else m_sm[a / 3] = wd[3:0];
    end else if (wv && a < 3 * NRT + NG) m_sg[a - 3 * NRT] = wd;
    if (rf && !sf && m_cnt < MAXI) m_cnt++;
    else if (sf && !rf && m_cnt > 0) m_cnt--;
    m_rv = rv;
    if (rv) m_idx = int'(ri);
  endtask
  task automatic fin();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic cyc();
    #4;
    model_check();
    fin();
  endtask
  task automatic idle();
    wv = 0; wa = '0; wd = '0; cv = 0; rf = 0; sf = 0; rv = 0; ri = '0; reset = 0;
  endtask
  typedef struct {
    logic wv; logic [AB-1:0] wa; logic [31:0] wd;
    logic cv, rf, sf, rv; logic [1:0] ri;
    logic x_ready, x_block, x_rdv; logic [31:0] x_addr; logic [3:0] x_mask; logic [31:0] x_g0; logic x_err;
  } vec_t;
  vec_t tab [20];
  bit hold;
  initial begin
    tab[0]  = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 4'h0, 0, 0};
    tab[1]  = '{1, 6, 32'h8000_0000, 0, 0, 0, 1, 2, 0, 0, 1, 0, 4'hF, 0, 0};
    tab[2]  = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 4'hF, 0, 0};
    tab[3]  = '{0, 0, 0, 1, 0, 0, 1, 2, 1, 1, 1, 0, 4'hF, 0, 0};
    tab[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0000, 4'hF, 0, 0};
    tab[5]  = '{1, 12, 32'h1234, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0};
    tab[6]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0};
    tab[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0};
    tab[8]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0};
    tab[9]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0};
    tab[10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0};
    tab[11] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'h0, 0, 0};
    tab[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 0, 0};
    tab[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h1234, 0};
    tab[14] = '{1, 28, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h1234, 0};
    tab[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h1234, 1};
    tab[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h1234, 0};
    tab[17] = '{1, 12, 32'h55, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 32'h1234, 0};
    tab[18] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 32'h1234, 0};
    tab[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h55, 0};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      wv = tab[i].wv; wa = tab[i].wa; wd = tab[i].wd; cv = tab[i].cv;
      rf = tab[i].rf; sf = tab[i].sf; rv = tab[i].rv; ri = tab[i].ri;
      #4;
      model_check();
      chk($sformatf("row%0d_ready", i), commit_ready, tab[i].x_ready);
      chk($sformatf("row%0d_block", i), req_block, tab[i].x_block);
      chk($sformatf("row%0d_rdv", i), rd_valid_o, tab[i].x_rdv);
      chk($sformatf("row%0d_addr", i), cbuf_addr, tab[i].x_addr);
      chk($sformatf("row%0d_mask", i), cbuf_writemask, tab[i].x_mask);
      chk($sformatf("row%0d_g0", i), global_state[31:0], tab[i].x_g0);
      chk($sformatf("row%0d_err", i), dcr_wr_err, tab[i].x_err);
      fin();
    end
    idle();
    // counter: 5 up, 10 balanced, then fill to the limit
    rf = 1;
    repeat (5) cyc();
    sf = 1;
    repeat (10) cyc();
    sf = 0;
    repeat (MAXI - 5) cyc();
    rf = 0;
    #4; model_check(); chk("full_at_max", inflight_full, 1); fin();
    rf = 1;
    cyc();
    rf = 0; sf = 1;
    repeat (MAXI - 1) cyc();
    cv = 1;
    #4; model_check(); chk("ready_cnt1", commit_ready, 0); fin();
    sf = 0;
    #4; model_check(); chk("ready_after_drain", commit_ready, 1); chk("full_after_drain", inflight_full, 0); fin();
    idle();
    // reset while draining drops the pending commit
    rf = 1; cyc();
    rf = 0; cv = 1;
    #4; model_check(); chk("drain_ready", commit_ready, 0); fin();
    cv = 0; reset = 1; cyc();
    reset = 0; wv = 1; wa = 8'd13; wd = 32'hCAFE;
    #4; model_check(); chk("post_reset_block", req_block, 0); chk("post_reset_full", inflight_full, 0); fin();
    idle();
    cyc();
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 299) == 0;
      wv = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      wd = $urandom;
      if (!hold && $urandom_range(0, 9) == 0) hold = 1;
      cv = hold && !reset;
      rf = !(cv || m_pend) && $urandom_range(0, 2) == 0;
      sf = m_cnt > 0 && $urandom_range(0, 2) != 0;
      rv = $urandom_range(0, 3) != 0;
      ri = 2'($urandom);
      #4;
      model_check();
      if (m_ready() || reset) hold = 0;
      fin();
    end
    idle();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
